// File: rtl/tetris_input_ctrl.sv
// Input command initiator for the tetris engine: buttons, gravity and garbage rows become single-cycle ctrl pulses.
// Optional gravity speed-up from the score is enabled with macro TETRIS_INPUT_LEVEL_EN.

package tetris_pkg;
  typedef enum logic [3:0] {
    NONE, WAIT, INIT, END, BAR, DROP, HOLD, ROTATE, ROTATE_REV, LEFT, RIGHT, DOWN
  } state_type;
endpackage

module tetris_input_ctrl
  import tetris_pkg::*;
#(
  parameter int unsigned DAS_CYCLES     = 10_000_000,
  parameter int unsigned ARR_CYCLES     = 3_000_000,
  parameter int unsigned GRAVITY_CYCLES = 50_000_000,
  parameter int unsigned CNT_W          = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_drop,
  input  logic       btn_rot,
  input  logic       btn_rot_rev,
  input  logic       btn_hold,
  input  state_type  engine_state,
  input  logic       bar_valid,
  input  logic [9:0] bar_data,
  output logic       bar_ready,
  input  logic [15:0] score,
  output state_type  ctrl,
  output logic [9:0] bar_mask
);

  localparam int unsigned NPEND = 8;
  localparam int unsigned NBTN  = 7;
  localparam int unsigned NRPT  = 3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} fsm_t;

  fsm_t                 state_q, state_d;
  state_type            ctrl_d, cmd_c;
  logic [NPEND-1:0]     pend, set_c, sel_c, clr_c;
  logic [NBTN-1:0]      btn_c, btn_q, rise_c;
  logic [9:0]           bar_buf;
  logic                 bar_hs_c, ready_c, issue_c;
  logic [CNT_W-1:0]     rpt_cnt [NRPT];
  logic [NRPT-1:0]      rpt_phase, rpt_tick_c;
  logic [CNT_W-1:0]     grav_cnt, grav_period, period_c;
  logic                 grav_hold_c, grav_tick_c, grav_restart_c;

  // Pending bit order doubles as issue priority: BAR highest, DOWN lowest
  assign btn_c    = {btn_drop, btn_hold, btn_rot, btn_rot_rev, btn_left, btn_right, btn_down};
  assign rise_c   = btn_c & ~btn_q;
  assign ready_c  = engine_state inside {WAIT, INIT, END};
  assign bar_hs_c = bar_valid && bar_ready && (bar_data != 10'd0);

`ifdef TETRIS_INPUT_LEVEL_EN
  logic [2:0] level_c;
  logic       unused_score;
  assign level_c      = score[11] ? 3'd7 : score[10:8];
  assign period_c     = CNT_W'(GRAVITY_CYCLES) >> level_c;
  assign unused_score = ^{score[15:12], score[7:0]};
`else
  logic unused_score;
  assign period_c     = CNT_W'(GRAVITY_CYCLES);
  assign unused_score = ^score;
`endif

  // Auto-repeat ticks for LEFT, RIGHT, DOWN (bits 2..0)
  always_comb begin
    rpt_tick_c = '0;
    for (int i = 0; i < int'(NRPT); i++) begin
      rpt_tick_c[i] = btn_c[i] && (rpt_phase[i] ? (rpt_cnt[i] == CNT_W'(ARR_CYCLES - 1))
                                                : (rpt_cnt[i] == CNT_W'(DAS_CYCLES - 1)));
    end
  end

  assign grav_hold_c    = (engine_state == INIT) || (engine_state == END);
  assign grav_tick_c    = !grav_hold_c && (grav_cnt == grav_period - CNT_W'(1));
  assign grav_restart_c = grav_hold_c || grav_tick_c || (issue_c && sel_c[0]);

  assign set_c = {bar_hs_c, rise_c} | NPEND'(rpt_tick_c) | NPEND'(grav_tick_c);

  // Highest-priority pending command
  always_comb begin
    sel_c = '0;
    cmd_c = NONE;
    if      (pend[7]) begin sel_c[7] = 1'b1; cmd_c = BAR;        end
    else if (pend[6]) begin sel_c[6] = 1'b1; cmd_c = DROP;       end
    else if (pend[5]) begin sel_c[5] = 1'b1; cmd_c = HOLD;       end
    else if (pend[4]) begin sel_c[4] = 1'b1; cmd_c = ROTATE;     end
    else if (pend[3]) begin sel_c[3] = 1'b1; cmd_c = ROTATE_REV; end
    else if (pend[2]) begin sel_c[2] = 1'b1; cmd_c = LEFT;       end
    else if (pend[1]) begin sel_c[1] = 1'b1; cmd_c = RIGHT;      end
    else if (pend[0]) begin sel_c[0] = 1'b1; cmd_c = DOWN;       end
  end

  // Issue FSM next-state and command
  always_comb begin
    state_d = state_q;
    ctrl_d  = NONE;
    clr_c   = '0;
    issue_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ready_c && (pend != '0)) begin
          issue_c = 1'b1;
          clr_c   = sel_c;
          ctrl_d  = cmd_c;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_BUSY;
      S_BUSY:  if (ready_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ctrl      <= NONE;
      bar_mask  <= '0;
      bar_ready <= 1'b1;
      bar_buf   <= '0;
      pend      <= '0;
      btn_q     <= '0;
    end else begin
      state_q <= state_d;
      ctrl    <= ctrl_d;
      btn_q   <= btn_c;
      // Re-set in the issue cycle survives: a new event arrived after the one being served
      pend    <= (pend & ~clr_c) | set_c;
      if (bar_hs_c) begin
        bar_buf   <= bar_data;
        bar_ready <= 1'b0;
      end else if (issue_c && sel_c[7]) begin
        bar_mask  <= bar_buf;
        bar_ready <= 1'b1;
      end
    end
  end

  // DAS/ARR counters: cleared on release, first tick after DAS, then every ARR
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_phase <= '0;
      for (int i = 0; i < int'(NRPT); i++) rpt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NRPT); i++) begin
        if (!btn_c[i]) begin
          rpt_cnt[i]   <= '0;
          rpt_phase[i] <= 1'b0;
        end else if (rpt_tick_c[i]) begin
          rpt_cnt[i]   <= '0;
          rpt_phase[i] <= 1'b1;
        end else begin
          rpt_cnt[i]   <= rpt_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Gravity timer; period is re-sampled whenever the count restarts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grav_cnt    <= '0;
      grav_period <= CNT_W'(GRAVITY_CYCLES);
    end else if (grav_restart_c) begin
      grav_cnt    <= '0;
      grav_period <= period_c;
    end else begin
      grav_cnt    <= grav_cnt + CNT_W'(1);
    end
  end

endmodule
